// File: rtl/seq_mult8x8_ctrl.sv
// seq_mult8x8_ctrl: exact unsigned 8x8 multiplier that time-shares one 4x4
// combinational core over four cycles, with a shift-add accumulator.
//
// Handshake: a transfer happens on a rising clk edge where valid and ready
// are both high. Input side: in_ready is high only in IDLE, so operands are
// taken on the edge where in_valid && in_ready. Output side: out_valid stays
// high with P stable until the edge where out_ready is also high.

// 4x4 unsigned multiplier core: shift-add of gated copies of i_a.
module nr__4x4 (
  input  logic [3:0] i_a,
  input  logic [3:0] i_b,
  output logic [7:0] o_p
);
  // Sum i_a << k for every set bit k of i_b.
  always_comb begin
    o_p = 8'd0;
    for (int k = 0; k < 4; k++) begin
      if (i_b[k]) o_p = o_p + ({4'd0, i_a} << k);
    end
  end
endmodule

module seq_mult8x8_ctrl #(
  parameter bit SKIP_ZERO = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [7:0]  A,
  input  logic [7:0]  B,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] P,
  output logic        busy,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [1:0]  r_step;
  logic [7:0]  r_a;
  logic [7:0]  r_b;
  logic [15:0] r_acc;
  logic        r_out_valid;
  logic        r_busy;

  logic        w_accept;
  logic        w_zero;
  logic [3:0]  w_op_a;
  logic [3:0]  w_op_b;
  logic [7:0]  w_pp;
  logic [15:0] w_pp_sh;

  // Next-state decode; accept only from IDLE, zero operands may skip CALC.
  always_comb begin
    w_next   = r_state;
    w_accept = 1'b0;
    w_zero   = (A == 8'd0) || (B == 8'd0);
    case (r_state)
      S_IDLE: begin
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = (SKIP_ZERO && w_zero) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (r_step == 2'd3) w_next = S_DONE;
      end
      S_DONE: begin
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Pick the operand nibbles for the current step.
  always_comb begin
    w_op_a = r_a[3:0];
    w_op_b = r_b[3:0];
    case (r_step)
      2'd0: begin w_op_a = r_a[3:0]; w_op_b = r_b[3:0]; end
      2'd1: begin w_op_a = r_a[7:4]; w_op_b = r_b[3:0]; end
      2'd2: begin w_op_a = r_a[3:0]; w_op_b = r_b[7:4]; end
      default: begin w_op_a = r_a[7:4]; w_op_b = r_b[7:4]; end
    endcase
  end

  nr__4x4 u_core (
    .i_a (w_op_a),
    .i_b (w_op_b),
    .o_p (w_pp)
  );

  // Align the partial product to its weight; pp <= 225 so <<8 never loses bits.
  always_comb begin
    w_pp_sh = {8'd0, w_pp};
    case (r_step)
      2'd0:    w_pp_sh = {8'd0, w_pp};
      2'd1,
      2'd2:    w_pp_sh = {4'd0, w_pp, 4'd0};
      default: w_pp_sh = {w_pp, 8'd0};
    endcase
  end

  // Operand latch, step counter and accumulator; operands hold outside accept.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_a    <= 8'd0;
      r_b    <= 8'd0;
      r_acc  <= 16'd0;
      r_step <= 2'd0;
    end else if (w_accept) begin
      r_a    <= A;
      r_b    <= B;
      r_acc  <= 16'd0;
      r_step <= 2'd0;
    end else if (r_state == S_CALC) begin
      r_acc  <= r_acc + w_pp_sh;
      r_step <= r_step + 2'd1;
    end
  end

  // Registered status outputs, aligned with the state they describe.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_out_valid <= (w_next == S_DONE);
      r_busy      <= (w_next != S_IDLE);
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign P         = r_acc;
  assign dbg_state = r_state;

endmodule

// File: tb/tb_seq_mult8x8_ctrl.sv
// Bench for seq_mult8x8_ctrl: directed cases with literal expectations plus
// randomized traffic checked every cycle against a latency/queue model.
module tb_seq_mult8x8_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid, out_ready;
  logic [7:0]  A, B;
  logic        in_ready, out_valid, busy;
  logic [15:0] P;
  logic [1:0]  dbg_state;

  // second instance without zero skip
  logic        n_in_valid, n_out_ready;
  logic [7:0]  n_A, n_B;
  logic        n_in_ready, n_out_valid, n_busy;
  logic [15:0] n_P;
  logic [1:0]  n_dbg_state;

  seq_mult8x8_ctrl #(.SKIP_ZERO(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready), .P(P),
    .busy(busy), .dbg_state(dbg_state)
  );

  seq_mult8x8_ctrl #(.SKIP_ZERO(1'b0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .A(n_A), .B(n_B), .out_valid(n_out_valid), .out_ready(n_out_ready), .P(n_P),
    .busy(n_busy), .dbg_state(n_dbg_state)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: an accepted operation yields A*B after a fixed number
  // of edges (4, or 0 extra edges for a zero operand), then waits for out_ready.
  bit          m_on = 1'b0;
  bit          m_busy = 1'b0;
  bit          m_pzero = 1'b0;
  int          m_cnt = 0;
  logic [15:0] m_res = 16'd0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_on = 1'b1; m_busy = 1'b0; m_cnt = 0; m_pzero = 1'b1; m_res = 16'd0;
      exp_q.delete();
    end else if (m_on) begin
      if (!m_busy) begin
        if (in_valid) begin
          m_busy  = 1'b1;
          m_res   = {8'd0, A} * {8'd0, B};
          m_cnt   = (A == 8'd0 || B == 8'd0) ? 0 : 4;
          m_pzero = 1'b0;
          exp_q.push_back(m_res);
        end
      end else if (m_cnt > 0) begin
        m_cnt--;
      end else if (out_ready) begin
        m_busy = 1'b0;
      end
    end
  end

  // Per-cycle compare, sampled on the falling edge.
  always @(negedge clk) begin
    if (m_on) begin
      chk("in_ready", {31'd0, in_ready}, {31'd0, !m_busy});
      chk("out_valid", {31'd0, out_valid}, {31'd0, (m_busy && m_cnt == 0)});
      chk("busy", {31'd0, busy}, {31'd0, m_busy});
      if (m_busy && m_cnt == 0) chk("P_done", {16'd0, P}, {16'd0, m_res});
      if (m_pzero) chk("P_after_reset", {16'd0, P}, 32'd0);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) chk("out_without_accept", {31'd0, out_valid}, 32'd0);
        else chk("in_order_P", {16'd0, P}, {16'd0, exp_q.pop_front()});
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input logic [7:0] a, input logic [7:0] b);
    int n = 0;
    while (!in_ready && n < 20) begin @(posedge clk); #1; n++; end
    chk("send_in_ready", {31'd0, in_ready}, 32'd1);
    A = a; B = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    A = 8'($urandom); B = 8'($urandom);
  endtask

  // Edges after the accept edge until out_valid is seen.
  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
    if (!out_valid) chk("out_valid_timeout", {31'd0, out_valid}, 32'd1);
  endtask

  task automatic consume();
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  function automatic logic [7:0] pick();
    int r = $urandom_range(0, 9);
    if (r == 0) return 8'd0;
    if (r == 1) return 8'hFF;
    return 8'($urandom_range(0, 255));
  endfunction

  logic [15:0] t2_exp[4] = '{16'h003C, 16'h012C, 16'h08AC, 16'h26AC};

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    logic [7:0] a, b;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = 8'd0; B = 8'd0;
    n_in_valid = 1'b0; n_out_ready = 1'b0; n_A = 8'd0; n_B = 8'd0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("reset_in_ready", {31'd0, in_ready}, 32'd1);
    chk("reset_P", {16'd0, P}, 32'd0);

    // max operands, immediate consumption, one-cycle pulse
    send(8'hFF, 8'hFF);
    out_ready = 1'b1;
    wait_out(lat);
    chk("t1_latency", lat, 32'd4);
    chk("t1_P", {16'd0, P}, 32'hFE01);
    @(posedge clk); #1;
    chk("t1_pulse_drop", {31'd0, out_valid}, 32'd0);
    out_ready = 1'b0;

    // accumulator after each step
    send(8'h3C, 8'hA5);
    chk("t2_acc_cleared", {16'd0, P}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      chk("t2_acc_step", {16'd0, P}, {16'd0, t2_exp[i]});
    end
    chk("t2_out_valid", {31'd0, out_valid}, 32'd1);
    consume();

    // zero skip: out_valid right after the accept edge
    send(8'h00, 8'hC8);
    wait_out(lat);
    chk("t3_skip_latency", lat, 32'd0);
    chk("t3_skip_P", {16'd0, P}, 32'd0);
    consume();
    send(8'h5A, 8'h00);
    wait_out(lat);
    chk("t3_skipB_latency", lat, 32'd0);
    consume();

    // stall with ignored in_valid pulses; in_valid also high on the handshake edge
    send(8'h12, 8'h34);
    wait_out(lat);
    chk("t4_latency", lat, 32'd4);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; A = 8'($urandom); B = 8'($urandom);
      @(posedge clk); #1;
      chk("t4_in_ready", {31'd0, in_ready}, 32'd0);
      chk("t4_hold_valid", {31'd0, out_valid}, 32'd1);
      chk("t4_hold_P", {16'd0, P}, 32'h03A8);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_no_accept_in_done", {31'd0, busy}, 32'd0);

    // reset in the middle of CALC
    send(8'h80, 8'h80);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("t5_in_ready", {31'd0, in_ready}, 32'd1);
    chk("t5_out_valid", {31'd0, out_valid}, 32'd0);
    chk("t5_P", {16'd0, P}, 32'd0);
    send(8'd7, 8'd9);
    wait_out(lat);
    chk("t5_next_P", {16'd0, P}, 32'd63);
    consume();

    // randomized traffic with stalls, garbage in_valid and rare resets
    for (int c = 0; c < 30000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      A = pick(); B = pick();
      out_ready = ($urandom_range(0, 2) != 0);
      rst_n     = ($urandom_range(0, 1999) != 0);
      @(posedge clk); #1;
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (10) begin @(posedge clk); #1; end
    out_ready = 1'b0;
    chk("drain_queue_empty", exp_q.size(), 32'd0);

    // no-skip instance: always four steps
    for (int i = 0; i < 6; i++) begin
      case (i)
        0: begin a = 8'h00; b = 8'hC8; end
        1: begin a = 8'hC8; b = 8'h00; end
        2: begin a = 8'h00; b = 8'h00; end
        3: begin a = 8'hFF; b = 8'hFF; end
        default: begin a = pick(); b = pick(); end
      endcase
      chk("ns_in_ready", {31'd0, n_in_ready}, 32'd1);
      n_A = a; n_B = b; n_in_valid = 1'b1;
      @(posedge clk); #1;
      n_in_valid = 1'b0;
      lat = 0;
      while (!n_out_valid && lat < 20) begin @(posedge clk); #1; lat++; end
      chk("ns_latency", lat, 32'd4);
      chk("ns_P", {16'd0, n_P}, {16'd0, {8'd0, a} * {8'd0, b}});
      n_out_ready = 1'b1;
      @(posedge clk); #1;
      n_out_ready = 1'b0;
      chk("ns_drop", {31'd0, n_out_valid}, 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
